// File: rtl/jtopl_pg_pkg.sv
// Shared definitions for the phase generator: increment width and saturation
// limit, plus the vibrato depth levels selected by the vibrato position.
package jtopl_pg_pkg;

    localparam int                  PHINC_W   = 17;
    localparam logic [PHINC_W-1:0]  PHINC_MAX = 17'h1FFFF;

    typedef enum logic [1:0] {
        VIB_ZERO = 2'd0,
        VIB_HALF = 2'd1,
        VIB_FULL = 2'd2
    } vib_lvl_e;

    // The low two bits give the depth within a half cycle; bit 2 is the sign.
    function automatic vib_lvl_e vib_level(input logic [2:0] pos);
        vib_lvl_e lvl;
        case (pos[1:0])
            2'd0:    lvl = VIB_ZERO;
            2'd2:    lvl = VIB_FULL;
            default: lvl = VIB_HALF;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/jtopl_pg_vibcnt.sv
// Vibrato position counter: a sample prescaler that advances the 3-bit
// vibrato position once every 2^VIB_PRE_W samples.
module jtopl_pg_vibcnt
    import jtopl_pg_pkg::*;
#(
    parameter int VIB_PRE_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       zero,
    output logic [2:0] vib_pos
);

    logic [VIB_PRE_W-1:0] prescaler;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            vib_pos   <= 3'd0;
        end else if (cen && zero) begin
            prescaler <= prescaler + 1'b1;
            if (&prescaler)
                vib_pos <= vib_pos + 3'd1;
        end
    end

endmodule

// File: rtl/jtopl_pg_inc.sv
// Phase-increment stage: turns F-number and block into the pure phase
// increment for the current slot, with vibrato applied and saturation.
module jtopl_pg_inc
    import jtopl_pg_pkg::*;
#(
    parameter int VIB_PRE_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    input  logic         zero,
    input  logic [9:0]   fnum,
    input  logic [2:0]   block,
    input  logic         vib,
    input  logic         dvb,
    output logic [16:0]  phinc_pure,
    output logic [2:0]   vib_pos
);

    // The magnitude never exceeds fnum[9:7], so the subtraction cannot wrap.
    function automatic logic [PHINC_W-1:0] calc_phinc(
        input logic [9:0] f,
        input logic [2:0] blk,
        input logic       vib_en,
        input logic       deep,
        input logic [2:0] pos
    );
        logic [2:0]  top;
        logic [2:0]  mag;
        logic [11:0] fmod;
        logic [18:0] inc;
        top = f[9:7];
        case (vib_level(pos))
            VIB_FULL: mag = top;
            VIB_HALF: mag = top >> 1;
            default:  mag = 3'd0;
        endcase
        if (!deep)
            mag = mag >> 1;
        if (!vib_en)
            mag = 3'd0;
        if (pos[2])
            fmod = {1'b0, f, 1'b0} - {9'd0, mag};
        else
            fmod = {1'b0, f, 1'b0} + {9'd0, mag};
        inc = ({7'd0, fmod} << blk) >> 1;
        if (inc > {2'b00, PHINC_MAX})
            return PHINC_MAX;
        return inc[PHINC_W-1:0];
    endfunction

    jtopl_pg_vibcnt #(
        .VIB_PRE_W (VIB_PRE_W)
    ) u_vibcnt (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .zero    (zero),
        .vib_pos (vib_pos)
    );

    // Uses the position before any update on this edge.
    always_ff @(posedge clk) begin
        if (rst)
            phinc_pure <= '0;
        else if (cen)
            phinc_pure <= calc_phinc(fnum, block, vib, dvb, vib_pos);
    end

endmodule

// File: tb/tb_jtopl_pg_inc.sv
// Bench for jtopl_pg_inc: sample-count model checked every cycle, plus
// hand-computed expectations along the directed sequence.
module tb_jtopl_pg_inc;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        zero;
    logic [9:0]  fnum;
    logic [2:0]  block;
    logic        vib;
    logic        dvb;
    logic [16:0] phinc_pure;
    logic [2:0]  vib_pos;

    int total = 0;
    int bad   = 0;

    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    jtopl_pg_inc dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .zero       (zero),
        .fnum       (fnum),
        .block      (block),
        .vib        (vib),
        .dvb        (dvb),
        .phinc_pure (phinc_pure),
        .vib_pos    (vib_pos)
    );

    // Increment from the written rules: vibrato shape over eight positions.
    function automatic int model_phinc(int f, int blk, int v, int d, int pos);
        int top, mag, fm, inc;
        top = f / 128;
        if (pos % 4 == 0)      mag = 0;
        else if (pos % 2 == 1) mag = top / 2;
        else                   mag = top;
        if (d == 0) mag = mag / 2;
        if (v == 0) mag = 0;
        fm  = (pos >= 4) ? 2 * f - mag : 2 * f + mag;
        inc = (fm * (1 << blk)) / 2;
        return (inc > 131071) ? 131071 : inc;
    endfunction

    // Model state: samples seen since reset and the held output.
    int m_samples = 0;
    int m_phinc   = 0;

    always @(posedge clk) begin
        int pos;
        if (rst) begin
            m_samples = 0;
            m_phinc   = 0;
        end else if (cen) begin
            pos     = (m_samples / 1024) % 8;
            m_phinc = model_phinc(int'(fnum), int'(block), int'(vib), int'(dvb), pos);
            if (zero)
                m_samples = m_samples + 1;
        end
        pos = (m_samples / 1024) % 8;
        exp_q.push_back({pos[2:0], m_phinc[16:0]});
    end

    always @(negedge clk) begin
        logic [19:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total = total + 1;
            if ({vib_pos, phinc_pure} !== e) begin
                bad = bad + 1;
                $display("FAIL model t=%0t: vib_pos=%0d phinc=%0d, want vib_pos=%0d phinc=%0d",
                         $time, vib_pos, phinc_pure, e[19:17], e[16:0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        cen  = 1'b1;
        zero = 1'b1;
        repeat (n) cyc();
        zero = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int want);
        total = total + 1;
        if (act != want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int held;
        rst = 1'b1; cen = 1'b1; zero = 1'b1;
        fnum = 10'h200; block = 3'd4; vib = 1'b0; dvb = 1'b1;

        // 1: reset, then plain increment
        cyc();
        check("rst_phinc_0", int'(phinc_pure), 0);
        check("rst_pos_0",   int'(vib_pos), 0);
        cyc();
        check("rst_phinc_1", int'(phinc_pure), 0);
        check("rst_pos_1",   int'(vib_pos), 0);
        rst = 1'b0; zero = 1'b0;
        cyc();
        check("plain_8192", int'(phinc_pure), 8192);

        // 2: vibrato depth and sign
        pulses(2048);
        check("pos_2", int'(vib_pos), 2);
        vib = 1'b1;
        cyc();
        check("pos2_dvb1", int'(phinc_pure), 8224);
        dvb = 1'b0;
        cyc();
        check("pos2_dvb0", int'(phinc_pure), 8208);
        dvb = 1'b1;
        pulses(4096);
        cyc();
        check("pos_6", int'(vib_pos), 6);
        check("pos6_dvb1", int'(phinc_pure), 8160);
        pulses(3072);
        cyc();
        check("pos_1_wrapped", int'(vib_pos), 1);
        check("pos1_dvb1", int'(phinc_pure), 8208);

        // 3: prescaler period and full cycle; zero without cen ignored
        do_reset();
        pulses(1023);
        check("pre_1023", int'(vib_pos), 0);
        pulses(1);
        check("pre_1024", int'(vib_pos), 1);
        pulses(8192 - 1024);
        check("pre_8192", int'(vib_pos), 0);
        held = int'(phinc_pure);
        cen = 1'b0; zero = 1'b1;
        fnum = 10'h3FF;
        repeat (5000) cyc();
        zero = 1'b0;
        check("cen0_pos", int'(vib_pos), 0);
        check("cen0_hold", int'(phinc_pure), held);
        fnum = 10'h200;
        pulses(1023);
        check("cen0_pre_1023", int'(vib_pos), 0);
        pulses(1);
        check("cen0_pre_1024", int'(vib_pos), 1);

        // 4: saturation
        pulses(1024);
        fnum = 10'd1023; block = 3'd7; vib = 1'b1; dvb = 1'b1;
        cyc();
        check("sat_pos", int'(vib_pos), 2);
        check("sat_max", int'(phinc_pure), 131071);
        vib = 1'b0;
        cyc();
        check("sat_novib", int'(phinc_pure), 130944);

        // 5: zero on the wrap edge uses the old position
        fnum = 10'h200; block = 3'd4; vib = 1'b0;
        do_reset();
        pulses(2047);
        check("wrap_pre_pos", int'(vib_pos), 1);
        vib = 1'b1; dvb = 1'b1; zero = 1'b1;
        cyc();
        zero = 1'b0;
        check("wrap_edge", int'(phinc_pure), 8208);
        check("wrap_pos", int'(vib_pos), 2);
        cyc();
        check("wrap_next", int'(phinc_pure), 8224);

        // 6: reset mid-stream
        pulses(3072);
        cyc();
        check("mid_pos5", int'(vib_pos), 5);
        check("mid_phinc", int'(phinc_pure), 8176);
        rst = 1'b1; zero = 1'b1;
        cyc();
        rst = 1'b0; zero = 1'b0;
        check("mid_rst_phinc", int'(phinc_pure), 0);
        check("mid_rst_pos", int'(vib_pos), 0);
        pulses(1023);
        check("mid_pre_1023", int'(vib_pos), 0);
        pulses(1);
        check("mid_pre_1024", int'(vib_pos), 1);

        cyc();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
